i2s_rx_frontend: RTL and testbench

Philips-I2S receiver that produces the filter chain's input strobe and samples. It oversamples the codec's I2S bit clock, word select and data using the system clock. It deserialises one stereo frame and presents left/right 16-bit two's-complement samples with a one-cycle sample_valid pulse, which drives the biquad filter's sample_valid/latest_sample. It also reports lock status and framing errors.

---
 rtl/audio_pkg.sv | 19 +
 rtl/sync_edge_det.sv | 50 +++++
 rtl/i2s_rx_frontend.sv | 162 ++++++++++++++++
 tb/tb_i2s_rx_frontend.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: types and constants shared by the I2S receive front end and the
// downstream filter chain.
//   rx_state_t          receiver framing state (HUNT / LEFT / RIGHT)
//   I2S_LEFT/I2S_RIGHT  word-select encoding of the two channels
//   AUDIO_SAMPLE_WIDTH  default sample width used across the audio path
package audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 16;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an asynchronous strobe line plus
// companion data lines, with a registered rising-edge detect.
//   clk       system clock
//   reset     asynchronous, active-high
//   edge_in   asynchronous line whose rising edges are detected (bit clock)
//   data_in   asynchronous lines sampled alongside edge_in
//   rise      one-clk pulse after a rising edge of edge_in
//   data_out  data_in, delayed exactly as much as rise
module sync_edge_det #(
    parameter int STAGES = 2,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              edge_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              rise,
    output logic [DATA_W-1:0] data_out
);

    // Bit 0 of each stage carries edge_in, the upper bits carry data_in, so
    // every line sees the same number of flops and the same delay.
    logic [STAGES-1:0][DATA_W:0] sync_reg;
    logic                        prev_reg;
    logic                        rise_reg;
    logic [DATA_W-1:0]           data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
            data_reg <= '0;
        end else begin
            sync_reg[0] <= {data_in, edge_in};
            for (int i = 1; i < STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            prev_reg <= sync_reg[STAGES-1][0];
            // Data is registered in the same cycle as the edge pulse so the
            // consumer sees ws/sd exactly as they were at the sck rise.
            rise_reg <= sync_reg[STAGES-1][0] & ~prev_reg;
            data_reg <= sync_reg[STAGES-1][DATA_W:1];
        end
    end

    assign rise     = rise_reg;
    assign data_out = data_reg;

endmodule

// File: rtl/i2s_rx_frontend.sv
// i2s_rx_frontend: Philips-I2S receiver. Oversamples sck/ws/sd with clk,
// deserialises one stereo frame and presents both channels together.
//   clk           system clock (>= 4x i2s_sck)
//   reset         asynchronous, active-high
//   i2s_sck       I2S bit clock (asynchronous)
//   i2s_ws        word select, 0 = left, 1 = right
//   i2s_sd        serial data, MSB first, sampled on sck rise
//   left_sample   last complete left word
//   right_sample  last complete right word of the same frame
//   sample_valid  one-clk strobe when both samples update
//   locked        high after a good frame, low after reset or framing error
//   frame_error   one-clk strobe when a slot ends short
module i2s_rx_frontend
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = AUDIO_SAMPLE_WIDTH,
    parameter int MAX_SLOT_BITS = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i2s_sck,
    input  logic                    i2s_ws,
    input  logic                    i2s_sd,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    locked,
    output logic                    frame_error
);

    localparam int CNT_W = $clog2(MAX_SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SW_M1   = CNT_W'(SAMPLE_WIDTH - 1);

    logic sck_rise;
    logic ws_s;
    logic sd_s;

    sync_edge_det #(
        .STAGES (SYNC_STAGES),
        .DATA_W (2)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .edge_in  (i2s_sck),
        .data_in  ({i2s_ws, i2s_sd}),
        .rise     (sck_rise),
        .data_out ({ws_s, sd_s})
    );

    rx_state_t               state_reg, state_next;
    logic                    ws_prev_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic [SAMPLE_WIDTH-2:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] left_hold_reg;
    logic [SAMPLE_WIDTH-1:0] left_sample_reg;
    logic [SAMPLE_WIDTH-1:0] right_sample_reg;
    logic                    sample_valid_reg;
    logic                    locked_reg;
    logic                    frame_error_reg;

    logic                    boundary;
    logic                    capture;
    logic                    word_done;
    logic                    slot_full;
    logic                    left_done;
    logic                    right_done;
    logic                    short_slot;
    logic [SAMPLE_WIDTH-1:0] shift_next;

    // The boundary rise still carries the LSB of the old slot, so that bit is
    // counted and captured before bit_cnt restarts. A slot therefore holds
    // bit_cnt+1 bits when its boundary arrives.
    assign boundary   = sck_rise && (ws_s != ws_prev_reg);
    assign capture    = sck_rise && (state_reg != HUNT) && (bit_cnt_reg <= SW_M1);
    assign shift_next = {shift_reg, sd_s};
    assign word_done  = capture && (bit_cnt_reg == SW_M1);
    assign slot_full  = (bit_cnt_reg >= SW_M1);
    assign left_done  = word_done && (state_reg == LEFT);
    assign right_done = word_done && (state_reg == RIGHT);
    assign short_slot = boundary && (state_reg != HUNT) && !slot_full;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (boundary) begin
            case (state_reg)
                HUNT: begin
                    if (ws_s == I2S_LEFT) state_next = LEFT;
                end
                LEFT: begin
                    if (slot_full)             state_next = RIGHT;
                    else if (ws_s == I2S_LEFT) state_next = LEFT;
                    else                       state_next = HUNT;
                end
                RIGHT: begin
                    // A short right slot still ends on a ws fall, so the
                    // receiver can resynchronise on the very next left slot.
                    if (slot_full || ws_s == I2S_LEFT) state_next = LEFT;
                    else                               state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_prev_reg      <= I2S_LEFT;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            left_hold_reg    <= '0;
            left_sample_reg  <= '0;
            right_sample_reg <= '0;
            sample_valid_reg <= 1'b0;
            locked_reg       <= 1'b0;
            frame_error_reg  <= 1'b0;
        end else begin
            if (sck_rise) begin
                ws_prev_reg <= ws_s;
                if (boundary) begin
                    bit_cnt_reg <= '0;
                end else if (bit_cnt_reg != CNT_MAX) begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end
            if (capture) begin
                shift_reg <= shift_next[SAMPLE_WIDTH-2:0];
            end
            if (left_done) begin
                left_hold_reg <= shift_next;
            end
            sample_valid_reg <= right_done;
            frame_error_reg  <= short_slot;
            if (right_done) begin
                left_sample_reg  <= left_hold_reg;
                right_sample_reg <= shift_next;
                locked_reg       <= 1'b1;
            end else if (short_slot) begin
                locked_reg <= 1'b0;
            end
        end
    end

    assign left_sample  = left_sample_reg;
    assign right_sample = right_sample_reg;
    assign sample_valid = sample_valid_reg;
    assign locked       = locked_reg;
    assign frame_error  = frame_error_reg;

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// tb_i2s_rx_frontend: drives an I2S stream into two receivers (2- and 3-stage
// synchronisers) and checks them against a slot-level reference model.
module tb_i2s_rx_frontend;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sck   = 1'b0;
    logic ws    = 1'b0;
    logic sd    = 1'b0;

    logic [15:0] l2, r2, l3, r3;
    logic        sv2, lk2, fe2, sv3, lk3, fe3;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    i2s_rx_frontend #(.SAMPLE_WIDTH(16), .MAX_SLOT_BITS(32), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
        .left_sample(l2), .right_sample(r2), .sample_valid(sv2),
        .locked(lk2), .frame_error(fe2)
    );

    i2s_rx_frontend #(.SAMPLE_WIDTH(16), .MAX_SLOT_BITS(32), .SYNC_STAGES(3)) dut3 (
        .clk(clk), .reset(reset), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
        .left_sample(l3), .right_sample(r3), .sample_valid(sv3),
        .locked(lk3), .frame_error(fe3)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: works per slot. mode 0 = hunting, 1 = in a left slot,
    // 2 = in a right slot.
    int          m_mode   = 0;
    logic        m_locked = 1'b0;
    logic [15:0] m_lhold  = '0;
    int          exp_err  = 0;
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    int          exp_cyc[$];

    int idx2 = 0, idx3 = 0, err2 = 0, err3 = 0;

    // Pin edges land 1..8 ns after a clk rise, never on one.
    task automatic half_wait();
        repeat (4) @(posedge clk);
        #($urandom_range(1, 8));
    endtask

    task automatic send_bit(input logic w, input logic d, input logic mark);
        ws = w;
        sd = d;
        half_wait();
        sck = 1'b1;
        if (mark) exp_cyc.push_back(cyc);
        half_wait();
        sck = 1'b0;
    endtask

    // One slot of n bits on channel c; ws moves to next_c on the slot's LSB.
    task automatic send_slot(input logic c, input int n, input logic [63:0] w, input logic next_c);
        logic        strobe;
        logic [15:0] top;
        top    = (n >= 16) ? 16'(w >> (n - 16)) : 16'h0;
        strobe = 1'b0;
        if (m_mode == 2 && n >= 16) begin
            strobe = 1'b1;
            exp_l.push_back(m_lhold);
            exp_r.push_back(top);
            m_locked = 1'b1;
        end
        if (m_mode == 1 && n >= 16) m_lhold = top;
        for (int j = 0; j < n; j++) begin
            send_bit((j == n - 1) ? next_c : c, w[n-1-j], strobe && (j == 15));
        end
        case (m_mode)
            0: if (next_c == 1'b0) m_mode = 1;
            default: begin
                if (n >= 16) begin
                    m_mode = (m_mode == 1) ? 2 : 1;
                end else begin
                    exp_err++;
                    m_locked = 1'b0;
                    m_mode   = (next_c == 1'b0) ? 1 : 0;
                end
            end
        endcase
    endtask

    task automatic settle_check(input string tag);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk({tag, " strobes s2"}, idx2, exp_l.size());
        chk({tag, " strobes s3"}, idx3, exp_l.size());
        chk({tag, " errors s2"}, err2, exp_err);
        chk({tag, " errors s3"}, err3, exp_err);
        chk({tag, " locked s2"}, lk2, m_locked);
        chk({tag, " locked s3"}, lk3, m_locked);
        $display("[%0t] %s: strobes=%0d errors=%0d locked=%0b", $time, tag, idx2, err2, lk2);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " left s2"}, l2, 0);
        chk({tag, " right s2"}, r2, 0);
        chk({tag, " valid s2"}, sv2, 0);
        chk({tag, " locked s2"}, lk2, 0);
        chk({tag, " ferr s2"}, fe2, 0);
        chk({tag, " left s3"}, l3, 0);
        chk({tag, " right s3"}, r3, 0);
        chk({tag, " locked s3"}, lk3, 0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Strobe monitor: each pulse is matched in order against the model and
    // timed against the sck pin rise of right bit 15.
    always @(negedge clk) begin
        if (sv2) begin
            if (idx2 < exp_l.size()) begin
                chk("s2 left", l2, exp_l[idx2]);
                chk("s2 right", r2, exp_r[idx2]);
                chk("s2 locked@strobe", lk2, 1);
                chk("s2 latency", cyc, exp_cyc[idx2] + 4);
                $display("[%0t] s2 strobe L=%h R=%h", $time, l2, r2);
            end else begin
                chk("s2 unexpected strobe", sv2, 0);
            end
            idx2++;
        end
        if (sv3) begin
            if (idx3 < exp_l.size()) begin
                chk("s3 left", l3, exp_l[idx3]);
                chk("s3 right", r3, exp_r[idx3]);
                chk("s3 locked@strobe", lk3, 1);
                chk("s3 latency", cyc, exp_cyc[idx3] + 5);
            end else begin
                chk("s3 unexpected strobe", sv3, 0);
            end
            idx3++;
        end
        if (fe2) err2++;
        if (fe3) err3++;
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        reset = 1'b0;

        // Clean 16-bit frame after a partial right slot
        send_slot(1'b1, 16, rnd64(), 1'b0);
        send_slot(1'b0, 16, 64'h8001, 1'b1);
        send_slot(1'b1, 16, 64'h7FFE, 1'b0);
        settle_check("clean16");

        // 32-bit slots: only the top 16 bits are kept
        send_slot(1'b0, 32, 64'h1234ABCD, 1'b1);
        send_slot(1'b1, 32, 64'hFFFF0000, 1'b0);
        settle_check("slot32");

        // Truncated right slot, then recovery
        send_slot(1'b0, 16, rnd64(), 1'b1);
        send_slot(1'b1, 10, rnd64(), 1'b0);
        settle_check("trunc_right");
        send_slot(1'b0, 16, 64'h0005, 1'b1);
        send_slot(1'b1, 16, 64'hFFFB, 1'b0);
        settle_check("relock");

        // Reset during bit 7 of a left slot
        for (int j = 0; j < 7; j++) send_bit(1'b0, 1'($urandom), 1'b0);
        ws = 1'b0;
        sd = 1'b1;
        half_wait();
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        repeat (3) @(posedge clk);
        #3;
        reset    = 1'b0;
        m_mode   = 0;
        m_locked = 1'b0;
        send_slot(1'b0, 9, rnd64(), 1'b1);
        send_slot(1'b1, 16, rnd64(), 1'b0);
        send_slot(1'b0, 16, rnd64(), 1'b1);
        send_slot(1'b1, 16, rnd64(), 1'b0);
        settle_check("reset_recover");

        // Reset, then start in the middle of a right slot
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset    = 1'b0;
        m_mode   = 0;
        m_locked = 1'b0;
        send_slot(1'b1, 7, rnd64(), 1'b0);
        send_slot(1'b0, 16, rnd64(), 1'b1);
        send_slot(1'b1, 16, rnd64(), 1'b0);
        settle_check("mid_right_start");

        // Short left slot drops back to hunting
        send_slot(1'b0, 12, rnd64(), 1'b1);
        send_slot(1'b1, 16, rnd64(), 1'b0);
        send_slot(1'b0, 16, rnd64(), 1'b1);
        send_slot(1'b1, 16, rnd64(), 1'b0);
        settle_check("short_left");

        // Random frames with assorted slot lengths, including beyond saturation
        for (int k = 0; k < 6; k++) begin
            int lens[5] = '{16, 20, 24, 32, 40};
            int n;
            n = lens[$urandom_range(0, 4)];
            send_slot(1'b0, n, rnd64(), 1'b1);
            send_slot(1'b1, n, rnd64(), 1'b0);
        end
        settle_check("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
